// File: rtl/mode_controller.sv
// mode_controller
//   Top-level mode selection controller. From MENU a note key picks a mode:
//   plain modes run directly, song modes pass through SELECT (difficulty and
//   song choice), and the setup mode walks through a key-remap sequence that
//   writes one table entry per accepted submit. A free-running tick divider
//   produces the system_clock count.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   submit, cancel,
//   oct_up, oct_down    : level buttons, edge-detected internally
//   clear               : level; aborts the remap sequence
//   snd_busy            : acknowledge tone still playing; blocks remap submits
//   note_key, length_key: one-hot keys (anything else is invalid)
//   state               : 0 MENU, 1 SELECT, 2 RUN, 3 SETUP
//   mode_en, sel        : one-hot running mode, active mode index
//   song, difficulty,
//   play_mod            : song (0 = none), difficulty level, length key index
//   system_clock        : tick count
//   remap_*             : remap table write port, progress count, done/clear pulses
//   snd_start           : one-cycle request for the acknowledge tone
module mode_controller #(
  parameter int                   NUM_MODES    = 5,
  parameter int                   KEY_BITS     = 7,
  parameter int                   NUM_SONGS    = 2,
  parameter logic [NUM_MODES-1:0] SONG_MASK    = 5'b01110,
  parameter int                   SETUP_IDX    = 4,
  parameter int                   DIFF_MAX     = 6,
  parameter int                   DIFF_DEFAULT = 4,
  parameter int                   TICK_DIV     = 100000,
  parameter int                   CLOCK_BITS   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               submit,
  input  logic                               cancel,
  input  logic                               oct_up,
  input  logic                               oct_down,
  input  logic                               clear,
  input  logic                               snd_busy,
  input  logic [KEY_BITS-1:0]                note_key,
  input  logic [KEY_BITS-1:0]                length_key,
  output logic [1:0]                         state,
  output logic [NUM_MODES-1:0]               mode_en,
  output logic [$clog2(NUM_MODES)-1:0]       sel,
  output logic [$clog2(NUM_SONGS+1)-1:0]     song,
  output logic [$clog2(DIFF_MAX+1)-1:0]      difficulty,
  output logic [$clog2(KEY_BITS)-1:0]        play_mod,
  output logic [CLOCK_BITS-1:0]              system_clock,
  output logic                               remap_we,
  output logic [KEY_BITS-1:0]                remap_addr,
  output logic [KEY_BITS-1:0]                remap_data,
  output logic [$clog2(KEY_BITS+1)-1:0]      remap_cnt,
  output logic                               remap_done,
  output logic                               remap_clear,
  output logic                               snd_start
);

  localparam int SEL_W  = $clog2(NUM_MODES);
  localparam int SONG_W = $clog2(NUM_SONGS + 1);
  localparam int DIFF_W = $clog2(DIFF_MAX + 1);
  localparam int PM_W   = $clog2(KEY_BITS);
  localparam int CNT_W  = $clog2(KEY_BITS + 1);
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [NUM_MODES-1:0] MODE_ONE = 1;
  localparam logic [KEY_BITS-1:0]  KEY_ONE  = 1;

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    SELECT = 2'd1,
    RUN    = 2'd2,
    SETUP  = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_MODES-1:0] mode_en_reg, mode_en_next;
  logic [SEL_W-1:0]     sel_reg, sel_next;
  logic [SONG_W-1:0]    song_reg, song_next;
  logic [DIFF_W-1:0]    diff_reg, diff_next;
  logic [PM_W-1:0]      pm_reg, pm_next;
  logic                 we_reg, we_next;
  logic [KEY_BITS-1:0]  addr_reg, addr_next;
  logic [KEY_BITS-1:0]  data_reg, data_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 done_reg, done_next;
  logic                 clr_reg, clr_next;
  logic                 start_reg, start_next;

  // Edge detection. armed_reg stays low for the first cycle out of reset so a
  // button held through reset release only loads the history, never fires.
  logic [3:0] btn_now, btn_prev_reg, btn_evt;
  logic       armed_reg;
  logic       submit_evt, cancel_evt, up_evt, down_evt;

  assign btn_now    = {oct_down, oct_up, cancel, submit};
  assign btn_evt    = btn_now & ~btn_prev_reg & {4{armed_reg}};
  assign submit_evt = btn_evt[0];
  assign cancel_evt = btn_evt[1];
  assign up_evt     = btn_evt[2];
  assign down_evt   = btn_evt[3];

  // Key decode: index is only meaningful when the matching _ok flag is set.
  logic note_ok, len_ok;
  int   note_i, len_i;

  always_comb begin
    note_ok = $onehot(note_key);
    len_ok  = $onehot(length_key);
    note_i  = 0;
    len_i   = 0;
    for (int k = 0; k < KEY_BITS; k++) begin
      if (note_key[k])   note_i = k;
      if (length_key[k]) len_i  = k;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mode_en_next = mode_en_reg;
    sel_next     = sel_reg;
    song_next    = song_reg;
    diff_next    = diff_reg;
    pm_next      = pm_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    cnt_next     = cnt_reg;
    we_next      = 1'b0;
    done_next    = 1'b0;
    clr_next     = 1'b0;
    start_next   = 1'b0;

    if (cancel_evt && state_reg != MENU) begin
      // cancel outranks everything else seen in the same cycle
      state_next   = MENU;
      mode_en_next = '0;
      song_next    = '0;
      sel_next     = '0;
    end else begin
      case (state_reg)
        MENU: begin
          if (submit_evt && note_ok && note_i < NUM_MODES) begin
            sel_next = SEL_W'(note_i);
            if (note_i == SETUP_IDX) begin
              state_next = SETUP;
              cnt_next   = '0;
            end else if (|(SONG_MASK & (MODE_ONE << note_i))) begin
              state_next = SELECT;
              song_next  = '0;
              diff_next  = DIFF_W'(DIFF_DEFAULT);
            end else begin
              state_next   = RUN;
              mode_en_next = MODE_ONE << note_i;
            end
          end
        end
        SELECT: begin
          // simultaneous up and down cancel each other out
          if (up_evt && !down_evt && diff_reg < DIFF_W'(DIFF_MAX))
            diff_next = diff_reg + 1'b1;
          else if (down_evt && !up_evt && diff_reg != '0)
            diff_next = diff_reg - 1'b1;
          if (submit_evt && note_ok && note_i < NUM_SONGS) begin
            song_next    = SONG_W'(note_i + 1);
            pm_next      = len_ok ? PM_W'(len_i) : '0;
            state_next   = RUN;
            mode_en_next = MODE_ONE << sel_reg;
          end
        end
        RUN: begin
          // outputs hold; only cancel (handled above) leaves RUN
        end
        SETUP: begin
          if (clear) begin
            clr_next   = 1'b1;
            cnt_next   = '0;
            state_next = MENU;
          end else if (cnt_reg >= CNT_W'(KEY_BITS)) begin
            done_next  = 1'b1;
            state_next = MENU;
          end else if (submit_evt && !snd_busy) begin
            // a submit while the tone is busy is dropped, not queued
            we_next    = 1'b1;
            addr_next  = note_key;
            data_next  = KEY_ONE << cnt_reg;
            cnt_next   = cnt_reg + 1'b1;
            start_next = 1'b1;
          end
        end
        default: state_next = MENU;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= MENU;
      mode_en_reg  <= '0;
      sel_reg      <= '0;
      song_reg     <= '0;
      diff_reg     <= DIFF_W'(DIFF_DEFAULT);
      pm_reg       <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      clr_reg      <= 1'b0;
      start_reg    <= 1'b0;
      btn_prev_reg <= '0;
      armed_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_en_reg  <= mode_en_next;
      sel_reg      <= sel_next;
      song_reg     <= song_next;
      diff_reg     <= diff_next;
      pm_reg       <= pm_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      cnt_reg      <= cnt_next;
      done_reg     <= done_next;
      clr_reg      <= clr_next;
      start_reg    <= start_next;
      btn_prev_reg <= btn_now;
      armed_reg    <= 1'b1;
    end
  end

  // Tick divider: system_clock advances once every TICK_DIV cycles.
  logic [DIV_W-1:0]      div_reg;
  logic [CLOCK_BITS-1:0] tick_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg  <= '0;
      tick_reg <= '0;
    end else if (div_reg == DIV_W'(TICK_DIV - 1)) begin
      div_reg  <= '0;
      tick_reg <= tick_reg + 1'b1;
    end else begin
      div_reg  <= div_reg + 1'b1;
    end
  end

  assign state        = state_reg;
  assign mode_en      = mode_en_reg;
  assign sel          = sel_reg;
  assign song         = song_reg;
  assign difficulty   = diff_reg;
  assign play_mod     = pm_reg;
  assign system_clock = tick_reg;
  assign remap_we     = we_reg;
  assign remap_addr   = addr_reg;
  assign remap_data   = data_reg;
  assign remap_cnt    = cnt_reg;
  assign remap_done   = done_reg;
  assign remap_clear  = clr_reg;
  assign snd_start    = start_reg;

endmodule

// File: tb/tb_mode_controller.sv
// tb_mode_controller
//   Directed bench for mode_controller (TICK_DIV reduced to 4). A table of
//   single-cycle vectors covers MENU/SELECT/RUN behaviour; hand-written
//   sequences cover the remap walk, clear, cancel in SETUP, the tick divider
//   and reset in the middle of RUN with a key held through release.
module tb_mode_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       submit = 1'b0, cancel = 1'b0, oct_up = 1'b0, oct_down = 1'b0;
  logic       clear = 1'b0, snd_busy = 1'b0;
  logic [6:0] note_key = '0, length_key = '0;

  logic [1:0]  state;
  logic [4:0]  mode_en;
  logic [2:0]  sel;
  logic [1:0]  song;
  logic [2:0]  difficulty;
  logic [2:0]  play_mod;
  logic [15:0] system_clock;
  logic        remap_we;
  logic [6:0]  remap_addr, remap_data;
  logic [2:0]  remap_cnt;
  logic        remap_done, remap_clear, snd_start;

  mode_controller #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .submit(submit), .cancel(cancel), .oct_up(oct_up), .oct_down(oct_down),
    .clear(clear), .snd_busy(snd_busy),
    .note_key(note_key), .length_key(length_key),
    .state(state), .mode_en(mode_en), .sel(sel), .song(song),
    .difficulty(difficulty), .play_mod(play_mod), .system_clock(system_clock),
    .remap_we(remap_we), .remap_addr(remap_addr), .remap_data(remap_data),
    .remap_cnt(remap_cnt), .remap_done(remap_done), .remap_clear(remap_clear),
    .snd_start(snd_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample just after the rise.
  task automatic step(input logic s, input logic c, input logic u, input logic d,
                      input logic cl, input logic busy,
                      input logic [6:0] nk, input logic [6:0] lk);
    @(negedge clk);
    submit = s; cancel = c; oct_up = u; oct_down = d;
    clear = cl; snd_busy = busy; note_key = nk; length_key = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 7'b0, 7'b0);
  endtask

  typedef struct {
    logic       sub, can, up, dn;
    logic [6:0] note, len;
    logic [1:0] e_state;
    logic [4:0] e_mode;
    logic [2:0] e_sel;
    logic [1:0] e_song;
    logic [2:0] e_diff;
    logic [2:0] e_pm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic c, input logic u, input logic d,
                              input logic [6:0] nk, input logic [6:0] lk,
                              input logic [1:0] st, input logic [4:0] me,
                              input logic [2:0] sl, input logic [1:0] sg,
                              input logic [2:0] df, input logic [2:0] pm);
    vec_t v;
    v.sub = s; v.can = c; v.up = u; v.dn = d; v.note = nk; v.len = lk;
    v.e_state = st; v.e_mode = me; v.e_sel = sl; v.e_song = sg;
    v.e_diff = df; v.e_pm = pm;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] key_v;
    logic [6:0] data_v;

    //             sub can up dn  note        len          st  mode      sel  song diff pm
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 4, 0)); // v0
    vecs.push_back(mk(1,0,0,0, 7'b0000001, 7'b0000000, 2, 5'b00001, 0, 0, 4, 0)); // mode0 -> RUN
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 2, 5'b00001, 0, 0, 4, 0));
    vecs.push_back(mk(0,1,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 4, 0)); // cancel
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 4, 0));
    vecs.push_back(mk(1,0,0,0, 7'b0000011, 7'b0000000, 0, 5'b00000, 0, 0, 4, 0)); // two bits: invalid
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 4, 0));
    vecs.push_back(mk(1,0,0,0, 7'b0100000, 7'b0000000, 0, 5'b00000, 0, 0, 4, 0)); // idx 5 out of range
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 4, 0));
    vecs.push_back(mk(1,0,0,0, 7'b0001000, 7'b0000000, 1, 5'b00000, 3, 0, 4, 0)); // mode3 -> SELECT
    vecs.push_back(mk(0,0,1,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 3, 0, 5, 0)); // up
    vecs.push_back(mk(0,0,1,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 3, 0, 5, 0)); // up held: no event
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 3, 0, 5, 0));
    vecs.push_back(mk(0,0,1,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 3, 0, 6, 0)); // up
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 3, 0, 6, 0));
    vecs.push_back(mk(0,0,1,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 3, 0, 6, 0)); // saturate
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 3, 0, 6, 0));
    vecs.push_back(mk(0,0,1,1, 7'b0000000, 7'b0000000, 1, 5'b00000, 3, 0, 6, 0)); // up+down
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 3, 0, 6, 0));
    vecs.push_back(mk(1,0,0,0, 7'b0000010, 7'b0000100, 2, 5'b01000, 3, 2, 6, 2)); // song 2, pm 2
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 2, 5'b01000, 3, 2, 6, 2));
    vecs.push_back(mk(1,0,0,0, 7'b0000001, 7'b0000000, 2, 5'b01000, 3, 2, 6, 2)); // RUN holds
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 2, 5'b01000, 3, 2, 6, 2));
    vecs.push_back(mk(0,1,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 6, 2)); // cancel
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 6, 2));
    vecs.push_back(mk(0,1,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 6, 2)); // cancel in MENU
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 6, 2));
    vecs.push_back(mk(1,0,0,0, 7'b0000100, 7'b0000000, 1, 5'b00000, 2, 0, 4, 2)); // mode2 -> SELECT
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 2, 0, 4, 2));
    vecs.push_back(mk(0,0,0,1, 7'b0000000, 7'b0000000, 1, 5'b00000, 2, 0, 3, 2)); // down
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 2, 0, 3, 2));
    vecs.push_back(mk(1,0,0,0, 7'b0000100, 7'b0000000, 1, 5'b00000, 2, 0, 3, 2)); // song idx 2: invalid
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 2, 0, 3, 2));
    vecs.push_back(mk(1,1,0,0, 7'b0000001, 7'b0000000, 0, 5'b00000, 0, 0, 3, 2)); // cancel beats submit
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 3, 2));
    vecs.push_back(mk(0,1,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 3, 2)); // cancel in MENU
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 3, 2));
    vecs.push_back(mk(1,0,0,0, 7'b0000010, 7'b0000000, 1, 5'b00000, 1, 0, 4, 2)); // mode1 -> SELECT
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 4, 2));
    vecs.push_back(mk(0,0,0,1, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 3, 2));
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 3, 2));
    vecs.push_back(mk(0,0,0,1, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 2, 2));
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 2, 2));
    vecs.push_back(mk(0,0,0,1, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 1, 2));
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 1, 2));
    vecs.push_back(mk(0,0,0,1, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 0, 2));
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 0, 2));
    vecs.push_back(mk(0,0,0,1, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 0, 2)); // saturate at 0
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 1, 5'b00000, 1, 0, 0, 2));
    vecs.push_back(mk(1,0,0,0, 7'b0000001, 7'b0000011, 2, 5'b00010, 1, 1, 0, 0)); // bad length -> pm 0
    vecs.push_back(mk(0,0,0,0, 7'b0000000, 7'b0000000, 2, 5'b00010, 1, 1, 0, 0));
    vecs.push_back(mk(0,1,0,0, 7'b0000000, 7'b0000000, 0, 5'b00000, 0, 0, 0, 0)); // cancel

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_diff", difficulty, 4);
    chk("rst_clock", system_clock, 0);
    $display("reset: state=%0d diff=%0d clock=%0d", state, difficulty, system_clock);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sub, vecs[i].can, vecs[i].up, vecs[i].dn, 0, 0, vecs[i].note, vecs[i].len);
      chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("v%0d_mode", i), mode_en, vecs[i].e_mode);
      chk($sformatf("v%0d_sel", i), sel, vecs[i].e_sel);
      chk($sformatf("v%0d_song", i), song, vecs[i].e_song);
      chk($sformatf("v%0d_diff", i), difficulty, vecs[i].e_diff);
      chk($sformatf("v%0d_pm", i), play_mod, vecs[i].e_pm);
      chk($sformatf("v%0d_we", i), remap_we, 0);
      $display("vec %0d: state=%0d mode=%b sel=%0d song=%0d diff=%0d pm=%0d",
               i, state, mode_en, sel, song, difficulty, play_mod);
    end

    // Remap walk: seven accepted submits, one busy submit dropped
    step(1, 0, 0, 0, 0, 0, 7'b0010000, 7'b0);
    chk("setup_state", state, 3);
    chk("setup_sel", sel, 4);
    chk("setup_cnt", remap_cnt, 0);
    idle();
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        step(1, 0, 0, 0, 0, 1, 7'b1000000, 7'b0);
        chk("busy_we", remap_we, 0);
        chk("busy_start", snd_start, 0);
        chk("busy_cnt", remap_cnt, 3);
        $display("remap busy submit: we=%0d cnt=%0d", remap_we, remap_cnt);
        idle();
      end
      key_v  = 7'b1000000;
      key_v  = key_v >> k;
      data_v = 7'd1;
      data_v = data_v << k;
      step(1, 0, 0, 0, 0, 0, key_v, 7'b0);
      chk($sformatf("remap%0d_we", k), remap_we, 1);
      chk($sformatf("remap%0d_start", k), snd_start, 1);
      chk($sformatf("remap%0d_addr", k), remap_addr, key_v);
      chk($sformatf("remap%0d_data", k), remap_data, data_v);
      chk($sformatf("remap%0d_cnt", k), remap_cnt, k + 1);
      $display("remap %0d: addr=%b data=%b cnt=%0d", k, remap_addr, remap_data, remap_cnt);
      idle();
      chk($sformatf("remap%0d_we_off", k), remap_we, 0);
      chk($sformatf("remap%0d_start_off", k), snd_start, 0);
      chk($sformatf("remap%0d_done", k), remap_done, (k == 6) ? 1 : 0);
      chk($sformatf("remap%0d_state", k), state, (k == 6) ? 0 : 3);
    end
    idle();
    chk("done_off", remap_done, 0);
    chk("done_state", state, 0);
    $display("remap finished: state=%0d done=%0d", state, remap_done);

    // clear during SETUP wins over a simultaneous submit
    step(1, 0, 0, 0, 0, 0, 7'b0010000, 7'b0);
    idle();
    step(1, 0, 0, 0, 0, 0, 7'b0000001, 7'b0);
    chk("clr_pre_cnt", remap_cnt, 1);
    idle();
    step(1, 0, 0, 0, 1, 0, 7'b0000010, 7'b0);
    chk("clr_pulse", remap_clear, 1);
    chk("clr_cnt", remap_cnt, 0);
    chk("clr_state", state, 0);
    chk("clr_we", remap_we, 0);
    idle();
    chk("clr_off", remap_clear, 0);
    $display("clear: state=%0d cnt=%0d", state, remap_cnt);

    // cancel out of SETUP with a partial count
    step(1, 0, 0, 0, 0, 0, 7'b0010000, 7'b0);
    idle();
    step(1, 0, 0, 0, 0, 0, 7'b0000100, 7'b0);
    idle();
    step(0, 1, 0, 0, 0, 0, 7'b0, 7'b0);
    chk("setup_cancel_state", state, 0);
    chk("setup_cancel_sel", sel, 0);
    $display("setup cancel: state=%0d sel=%0d", state, sel);

    // Into RUN with non-default outputs, then reset mid-run
    step(1, 0, 0, 0, 0, 0, 7'b0001000, 7'b0);
    idle();
    step(0, 0, 1, 0, 0, 0, 7'b0, 7'b0);
    idle();
    step(1, 0, 0, 0, 0, 0, 7'b0000010, 7'b0000100);
    chk("pre_rst_state", state, 2);
    chk("pre_rst_song", song, 2);
    chk("pre_rst_diff", difficulty, 5);
    @(negedge clk);
    rst = 1'b1;
    submit = 1'b1;
    note_key = 7'b0000001;
    @(posedge clk);
    #1;
    chk("rst_run_state", state, 0);
    chk("rst_run_mode", mode_en, 0);
    chk("rst_run_sel", sel, 0);
    chk("rst_run_song", song, 0);
    chk("rst_run_pm", play_mod, 0);
    chk("rst_run_diff", difficulty, 4);
    chk("rst_run_cnt", remap_cnt, 0);
    chk("rst_run_clock", system_clock, 0);
    chk("rst_run_pulses", {remap_we, snd_start, remap_done, remap_clear}, 0);
    $display("reset in RUN: state=%0d mode=%b song=%0d diff=%0d", state, mode_en, song, difficulty);

    // submit stays held through release; tick divider counts 12 cycles
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 11) chk("tick11", system_clock, 2);
    end
    chk("tick12", system_clock, 3);
    chk("held_key_state", state, 0);
    chk("held_key_mode", mode_en, 0);
    $display("after 12 cycles: clock=%0d state=%0d", system_clock, state);
    idle();
    step(1, 0, 0, 0, 0, 0, 7'b0000001, 7'b0);
    chk("fresh_press_state", state, 2);
    chk("fresh_press_mode", mode_en, 5'b00001);
    $display("fresh press: state=%0d mode=%b", state, mode_en);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_controller.md
MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_MODES, 5, selectable modes; KEY_BITS, 7, note/length key width; NUM_SONGS, 2, selectable songs; SONG_MASK, 5'b01110, modes needing song select; SETUP_IDX, 4, remap-setup mode index; DIFF_MAX, 6, top difficulty; DIFF_DEFAULT, 4, difficulty on select entry; TICK_DIV, 100000, clk cycles per tick; CLOCK_BITS, 16, tick counter width.
REQ-002 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock; rst, in, 1, synchronous active-high reset.
REQ-003 Inputs, all 1-bit level: submit, cancel, oct_up, oct_down, clear, snd_busy (acknowledge tone playing).
REQ-004 Inputs: note_key, KEY_BITS; length_key, KEY_BITS.
REQ-005 Outputs: state, 2, current state; mode_en, NUM_MODES, one-hot running mode; sel, clog2(NUM_MODES), active mode index; song, clog2(NUM_SONGS+1), 0 = none; difficulty, clog2(DIFF_MAX+1); play_mod, clog2(KEY_BITS); system_clock, CLOCK_BITS, tick count.
REQ-006 Remap outputs: remap_we, 1; remap_addr, KEY_BITS; remap_data, KEY_BITS; remap_cnt, clog2(KEY_BITS+1); remap_done, 1; remap_clear, 1; snd_start, 1.

Function
REQ-007 submit, cancel, oct_up and oct_down SHALL each be edge-detected internally: event = input high this cycle, low the previous cycle; one event per press.
REQ-008 All outputs SHALL be registered; an event's effect SHALL be visible one cycle after the cycle the event is detected.
REQ-009 A key is valid only if exactly one bit is set; its index is the position of that bit.
REQ-010 Tick divider: counter 0..TICK_DIV-1; at wrap system_clock increments, modulo 2^CLOCK_BITS.
REQ-011 States: MENU=0, SELECT=1, RUN=2, SETUP=3.
REQ-012 MENU, submit event with a valid note_key index i < NUM_MODES: i == SETUP_IDX -> SETUP, remap_cnt = 0; else SONG_MASK[i] -> SELECT, song = 0, difficulty = DIFF_DEFAULT; else -> RUN, mode_en = 1<<i. sel = i in all three cases.
REQ-013 MENU, invalid key or index >= NUM_MODES: no state change.
REQ-014 SELECT, oct_up event: difficulty + 1, saturating at DIFF_MAX. oct_down event: difficulty - 1, saturating at 0. Both in the same cycle: no change.
REQ-015 SELECT, submit event with a valid note_key index j < NUM_SONGS: song = j+1; play_mod = length_key index if valid, else 0; go to RUN; mode_en = 1<<sel. Otherwise stay in SELECT.
REQ-016 RUN: hold all outputs; exit only on cancel.
REQ-017 SETUP, submit event with snd_busy = 0 and remap_cnt < KEY_BITS: one-cycle remap_we; remap_addr = note_key; remap_data = 1<<remap_cnt; remap_cnt + 1; one-cycle snd_start.
REQ-018 SETUP, submit event while snd_busy = 1: ignored entirely; the event is not queued.
REQ-019 SETUP: on the cycle after remap_cnt reaches KEY_BITS, pulse remap_done for one cycle and go to MENU.
REQ-020 SETUP, clear high: one-cycle remap_clear, remap_cnt = 0, go to MENU. clear has priority over submit.
REQ-021 cancel event in any state other than MENU: go to MENU; mode_en = 0, song = 0, sel = 0.
REQ-022 cancel has priority over every other event in the same cycle.
REQ-023 cancel in MENU: ignored.
REQ-024 remap_we, snd_start, remap_done and remap_clear SHALL never be high for more than one consecutive cycle.

Reset
REQ-025 rst high at a clk edge SHALL force: state = MENU; mode_en, sel, song, play_mod, remap_cnt and all pulse outputs = 0; difficulty = DIFF_DEFAULT; system_clock and divider = 0; edge-detect history = 0.
REQ-026 Reset mid-operation SHALL abort any state immediately. A key held through reset release SHALL NOT generate an event.

Verification
REQ-027 MENU, note_key=7'b0000001, submit pulse -> RUN, mode_en=5'b00001, sel=0, song=0 (mode 0 not in SONG_MASK).
REQ-028 note_key=7'b0001000, submit -> SELECT, difficulty=4; 3x oct_up -> 6 (saturated); note_key=7'b0000010, length_key=7'b0000100, submit -> RUN, song=2, play_mod=2, mode_en=5'b01000.
REQ-029 SETUP via note_key=7'b0010000; 7 submits with snd_busy low -> remap_data 1,2,4..64, remap_cnt=7, remap_done pulse, then MENU; a submit with snd_busy high -> no remap_we.
REQ-030 cancel and submit in the same cycle in SELECT -> MENU, song=0; a second cancel in MENU -> no change.
REQ-031 TICK_DIV=4: 12 cycles after reset -> system_clock=3; rst asserted in RUN -> all REQ-025 values next cycle.
